// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetch sequencer feeding the decode stage.
// Owns the fetch PC, reads a 32-word instruction array and presents one
// registered instruction per cycle under a valid/ready handshake.
// Handles redirects (branch/jump/restart) and stops on a halt opcode.
// Optional build macro: STALL_COUNT_EN adds a saturating stall_cycles counter.
module instr_fetch_seq #(
    parameter int                WORD_W      = 20,
    parameter int                IMEM_DEPTH  = 32,
    parameter int                ADDR_W      = 5,
    parameter int                HALT_OPCODE = 31,
    parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IMEM_DEPTH-1:0][WORD_W-1:0] imem,
    input  logic                              redirect_en,
    input  logic [WORD_W-1:0]                 redirect_pc,
    input  logic                              instr_ready,
    output logic                              instr_valid,
    output logic [WORD_W-1:0]                 instr,
    output logic [WORD_W-1:0]                 pc,
`ifdef STALL_COUNT_EN
    output logic [15:0]                       stall_cycles,
`endif
    output logic                              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetchState_t;

    fetchState_t       stateReg;
    logic [WORD_W-1:0] fetchPc;

    // Combinational memory lookups; only the low index bits of a PC select a word
    logic [WORD_W-1:0] redirectWord;
    logic [WORD_W-1:0] resetWord;
    logic [WORD_W-1:0] nextWord;
    logic              isHaltWord;
    logic              transfer;

    assign redirectWord = imem[redirect_pc[ADDR_W-1:0]];
    assign resetWord    = imem[RESET_PC[ADDR_W-1:0]];
    assign nextWord     = imem[fetchPc[ADDR_W-1:0]];
    assign isHaltWord   = (instr[4:0] == 5'(HALT_OPCODE));
    assign transfer     = instr_valid & instr_ready;

    // Fetch FSM: redirect has top priority, then the per-state behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg    <= IDLE;
            fetchPc     <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            halted      <= 1'b0;
        end else if (redirect_en) begin
            // Any word still waiting for decode is dropped here
            stateReg    <= FETCH;
            instr       <= redirectWord;
            pc          <= redirect_pc;
            instr_valid <= 1'b1;
            fetchPc     <= redirect_pc + 1'b1;
            halted      <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateReg    <= FETCH;
                    instr       <= resetWord;
                    pc          <= RESET_PC;
                    instr_valid <= 1'b1;
                    fetchPc     <= RESET_PC + 1'b1;
                end
                FETCH: begin
                    if (transfer) begin
                        if (isHaltWord) begin
                            // Halt word was consumed; instr/pc keep it visible
                            stateReg    <= HALT;
                            instr_valid <= 1'b0;
                            halted      <= 1'b1;
                        end else begin
                            instr   <= nextWord;
                            pc      <= fetchPc;
                            fetchPc <= fetchPc + 1'b1;
                        end
                    end
                    // Stall: everything holds so instr stays bit-stable
                end
                HALT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    stateReg    <= IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_COUNT_EN
    // Count cycles where decode back-pressures a live word, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (instr_valid && !instr_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed bench for instr_fetch_seq with a scoreboard
// queue of expected post-edge outputs.
module tb_instr_fetch_seq;

    logic              clk;
    logic              rst;
    logic [31:0][19:0] imem;
    logic              redirect_en;
    logic [19:0]       redirect_pc;
    logic              instr_ready;
    logic              instr_valid;
    logic [19:0]       instr;
    logic [19:0]       pc;
    logic              halted;
`ifdef STALL_COUNT_EN
    logic [15:0]       stall_cycles;
`endif

    int testCnt = 0;
    int failCnt = 0;

    typedef struct {
        logic        v;
        logic [19:0] p;
        logic [19:0] w;
        logic        h;
    } exp_t;

    exp_t sb[$];

    instr_fetch_seq dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
`ifdef STALL_COUNT_EN
        .stall_cycles(stall_cycles),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] want);
        testCnt++;
        assert (got === want) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, compare after the edge
    task automatic cyc(input logic rdy, input logic rd, input logic [19:0] rpc,
                       input logic ev, input logic [19:0] epc, input logic [19:0] ew,
                       input logic eh);
        exp_t e;
        instr_ready = rdy;
        redirect_en = rd;
        redirect_pc = rpc;
        sb.push_back('{v: ev, p: epc, w: ew, h: eh});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            testCnt++;
            failCnt++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            $display("[TB] rdy=%b redir=%b rpc=%0d -> valid=%b pc=%0d instr=%h halted=%b",
                     rdy, rd, rpc, instr_valid, pc, instr, halted);
            chk("valid", {19'd0, instr_valid}, {19'd0, e.v});
            chk("pc", pc, e.p);
            chk("instr", instr, e.w);
            chk("halted", {19'd0, halted}, {19'd0, e.h});
        end
        redirect_en = 1'b0;
    endtask

    initial begin
        logic [19:0] saved;
        for (int i = 0; i < 32; i++) imem[i] = 20'h00401 + 20'(i) * 20'h01010;
        imem[5] = 20'h0AB1F;
        rst = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", {19'd0, instr_valid}, 20'd0);
        chk("rst_instr", instr, 20'd0);
        chk("rst_pc", pc, 20'd0);
        chk("rst_halted", {19'd0, halted}, 20'd0);
        rst = 1'b0;

        // First fetch one cycle after release, then straight line
        cyc(1, 0, 0, 1, 20'd0, 20'h00401, 0);
        cyc(1, 0, 0, 1, 20'd1, imem[1], 0);
        cyc(1, 0, 0, 1, 20'd2, imem[2], 0);

        // Stall three cycles at pc=2 while imem[2] changes underneath
        saved = imem[2];
        imem[2] = 20'hFFFF0;
        repeat (3) cyc(0, 0, 0, 1, 20'd2, saved, 0);
        imem[2] = saved;
`ifdef STALL_COUNT_EN
        chk("stall_cycles", {4'd0, stall_cycles}, 20'd3);
`endif
        cyc(1, 0, 0, 1, 20'd3, imem[3], 0);
        cyc(1, 0, 0, 1, 20'd4, imem[4], 0);
        cyc(1, 0, 0, 1, 20'd5, 20'h0AB1F, 0);

        // Halt word accepted, then outputs stay put
        cyc(1, 0, 0, 0, 20'd5, 20'h0AB1F, 1);
        repeat (10) cyc(1, 0, 0, 0, 20'd5, 20'h0AB1F, 1);

        // Redirect out of HALT
        cyc(1, 1, 20'd12, 1, 20'd12, imem[12], 0);
        cyc(1, 0, 0, 1, 20'd13, imem[13], 0);

        // Wrap-around past index 31
        cyc(1, 1, 20'd30, 1, 20'd30, imem[30], 0);
        cyc(1, 0, 0, 1, 20'd31, imem[31], 0);
        cyc(1, 0, 0, 1, 20'd32, imem[0], 0);
        cyc(1, 0, 0, 1, 20'd33, imem[1], 0);

        // Stall at pc=7 together with a redirect to 20
        cyc(1, 1, 20'd6, 1, 20'd6, imem[6], 0);
        cyc(1, 0, 0, 1, 20'd7, imem[7], 0);
        cyc(0, 1, 20'd20, 1, 20'd20, imem[20], 0);
        cyc(1, 0, 0, 1, 20'd21, imem[21], 0);

        // Halt transfer and redirect on the same edge: redirect wins
        cyc(1, 1, 20'd5, 1, 20'd5, 20'h0AB1F, 0);
        cyc(1, 1, 20'd9, 1, 20'd9, imem[9], 0);
        cyc(1, 0, 0, 1, 20'd10, imem[10], 0);

        // Redirect target beyond the array reports the full pc
        cyc(1, 1, 20'h00043, 1, 20'h00043, imem[3], 0);
        cyc(1, 0, 0, 1, 20'h00044, imem[4], 0);

        // Asynchronous reset mid-stream clears valid before any edge
        rst = 1'b1;
        #1;
        chk("async_valid", {19'd0, instr_valid}, 20'd0);
        chk("async_pc", pc, 20'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 1, 20'd0, imem[0], 0);
        cyc(1, 0, 0, 1, 20'd1, imem[1], 0);

        // Redirect in IDLE supersedes the reset PC
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 1, 20'd10, 1, 20'd10, imem[10], 0);
        cyc(1, 0, 0, 1, 20'd11, imem[11], 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
